rf_port_master: RTL
===================

Name: rf_port_master

Overview:
- Initiator-side controller for the team's 2R1W register file: it turns a valid/ready command stream into correctly timed RF write- and read-port activity.
- Returns read data on a valid/ready response stream.
- Adds two bulk operations: DUMP (stream every register out) and CLEAR (zero every writable register).
- Sits between a debug/host bus adapter and one register file instance; drives write port plus read port 1 only.

Parameters:
- AWL, 5, address word length; must equal the attached RF's AWL.
- DWL, 32, data word length; must equal the attached RF's DWL.
- RF_LAT, 0, read latency of the attached RF: 0 = asynchronous-read RF, 1 = write-first or read-first RF. Other values are illegal; flag with an elaboration-time error.

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command; high only in IDLE
- cmd_op  in  2  00 READ, 01 WRITE, 10 DUMP, 11 CLEAR
- cmd_addr  in  AWL  target address (READ/WRITE only)
- cmd_data  in  DWL  write data (WRITE only)
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  consumer accepts beat
- rsp_addr  out  AWL  address the beat refers to
- rsp_data  out  DWL  read data
- rsp_last  out  1  final beat of a command
- rf_wen  out  1  RF write enable
- rf_wa  out  AWL  RF write address
- rf_wd  out  DWL  RF write data
- rf_ra  out  AWL  RF read address 1
- rf_rd  in  DWL  RF read data 1
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge) forces state IDLE; cmd_ready=1; rsp_valid=0; rsp_last=0; rsp_addr=0; rsp_data=0; rf_wen=0; rf_wa=0; rf_wd=0; rf_ra=0; address counter=0; busy=0.
- Reset mid-DUMP/CLEAR abandons the operation at once; no further RF writes. RF contents already cleared stay cleared.
- States: IDLE, WR, RD, RD_WAIT, RSP, CLR.
- Handshake: command accepted on the cycle where cmd_valid & cmd_ready; cmd_* are registered on that cycle. A response beat transfers on rsp_valid & rsp_ready. rsp_* are registered and held stable while rsp_valid=1 and rsp_ready=0.
- WRITE, accepted at cycle T:
  - T+1 (WR): rf_wen=1, rf_wa=addr, rf_wd=data, for exactly one cycle.
  - T+2: back in IDLE.
  - addr==0: rf_wen stays 0 (address 0 is hardwired zero); still takes one WR cycle.
- READ, accepted at cycle T:
  - T+1 (RD): rf_ra=addr.
  - RF_LAT=0: rf_rd captured at the end of T+1.
  - RF_LAT=1: RD_WAIT at T+2, capture at the end of T+2.
  - rsp_valid rises at T+2+RF_LAT with rsp_last=1, rsp_addr=addr. Back to IDLE the cycle after the beat transfers.
- DUMP:
  - Counter runs 0 .. 2^AWL-1; each address follows the READ sequence.
  - The next address is issued only after the current beat transfers.
  - rsp_last=1 only on address 2^AWL-1.
  - Exactly 2^AWL beats; address 0 returns 0.
- CLEAR:
  - State CLR writes 0 to addresses 1 .. 2^AWL-1, one per cycle (rf_wen=1 each cycle); 2^AWL-1 cycles total, then IDLE.
  - No response beat unless the optional feature is enabled.
- Ordering: a write is committed to the RF before IDLE is re-entered, so any later READ returns the new value in every RF mode.
- Counter wrap: the counter is AWL+1 bits wide so the terminal test does not alias to 0.
- cmd_* changes while cmd_ready=0 are ignored.

Optional Feature:
- Macro: RF_PORT_MASTER_WACK_EN.
- Defined: WRITE and CLEAR each produce one response beat after their last RF write, with rsp_data=0, rsp_last=1, and rsp_addr = write address (WRITE) or 0 (CLEAR). IDLE is entered only after that beat transfers.
- Undefined: WRITE and CLEAR are fire-and-forget; no response beat.

Decomposition:
- Package rf_pkg holds:
  - typedef enum logic [1:0] rf_op_t {RF_READ, RF_WRITE, RF_DUMP, RF_CLEAR};
  - typedef enum state_t for the FSM;
  - localparam RF_LAT_MAX = 1.
- One sub-module: rf_addr_seq (loadable AWL+1-bit up-counter with start value, increment, and terminal flag), shared by DUMP and CLEAR.
- Everything else lives in rf_port_master.

Test Plan (AWL=5, DWL=32; run each with RF_LAT=0 against an async-read RF and RF_LAT=1 against a write-first RF):
- WRITE addr 3 data 0xDEADBEEF, then READ 3 → one rf_wen pulse with rf_wa=3; rsp_data=0xDEADBEEF, rsp_addr=3, rsp_last=1, rsp_valid at accept+2+RF_LAT.
- WRITE addr 0 data 0xFFFFFFFF, then READ 0 → rf_wen never asserted; rsp_data=0.
- Preload reg k = k*0x11 for k=1..31; DUMP with rsp_ready toggled every other cycle → 32 beats in address order, beat k = k*0x11, rsp_last only on beat 31, no beat dropped or duplicated.
- CLEAR after preload, then DUMP → exactly 31 rf_wen cycles (addresses 1..31); all 32 dump beats read 0.
- Assert rst for one cycle mid-DUMP after beat 10 → rsp_valid=0 and busy=0 the next cycle; cmd_ready=1; a new READ 5 returns 0x55.
- With RF_PORT_MASTER_WACK_EN: WRITE addr 7 → one beat with rsp_addr=7, rsp_data=0, rsp_last=1. Holding rsp_ready=0 keeps busy=1 and cmd_ready=0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and limits for the register-file port master
// Purpose: command opcodes, FSM state encoding and the legal read-latency limit,
//          imported by rf_addr_seq and rf_port_master.
// Ports:   none (package).
package rf_pkg;

  typedef enum logic [1:0] {
    RF_READ  = 2'b00,
    RF_WRITE = 2'b01,
    RF_DUMP  = 2'b10,
    RF_CLEAR = 2'b11
  } rf_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RSP     = 3'd4,
    ST_CLR     = 3'd5
  } state_t;

  // Largest supported RF read latency (0 = async read, 1 = registered read).
  localparam int RF_LAT_MAX = 1;

endpackage

// File: rtl/rf_addr_seq.sv
// rtl/rf_addr_seq.sv - loadable address sequencer shared by DUMP and CLEAR
// Purpose: AWL+1-bit up-counter; load_i takes priority over inc_i. The extra MSB
//          keeps the count from aliasing back to 0 after the top address.
// Ports:   clk, rst        clock, synchronous active-high reset (count -> 0)
//          load_i, start_i load the count with the AWL-bit start address
//          inc_i           advance the count by one
//          addr_o          current address (low AWL bits of the count)
//          last_o          count sits on the top address 2^AWL-1
module rf_addr_seq #(
  parameter int AWL = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [AWL-1:0] start_i,
  input  logic           inc_i,
  output logic [AWL-1:0] addr_o,
  output logic           last_o
);

  localparam logic [AWL:0] CNT_ONE  = (AWL+1)'(1);
  localparam logic [AWL:0] CNT_LAST = {1'b0, {AWL{1'b1}}};

  logic [AWL:0] cnt_q;
  logic [AWL:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = {1'b0, start_i};
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr_o = cnt_q[AWL-1:0];
  assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/rf_port_master.sv
// rtl/rf_port_master.sv - initiator controller driving a 2R1W register file from a command stream
// Purpose: accepts READ/WRITE/DUMP/CLEAR commands on a valid/ready stream, drives the
//          RF write port and read port 1, and returns read data on a valid/ready
//          response stream. Address 0 is never written (hardwired zero in the RF).
// Ports:   clk, rst                  clock, synchronous active-high reset
//          cmd_valid/ready/op/addr/data   command stream (accepted only in IDLE)
//          rsp_valid/ready/addr/data/last response stream (registered, held while stalled)
//          rf_wen, rf_wa, rf_wd      RF write port
//          rf_ra, rf_rd              RF read port 1
//          busy                      high whenever the FSM is not IDLE
// Params:  AWL, DWL must match the RF; RF_LAT = 0 (async read) or 1 (registered read).
// Macro:   RF_PORT_MASTER_WACK_EN - WRITE and CLEAR each return one zero-data beat.
module rf_port_master #(
  parameter int AWL    = 5,
  parameter int DWL    = 32,
  parameter int RF_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [AWL-1:0] cmd_addr,
  input  logic [DWL-1:0] cmd_data,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [AWL-1:0] rsp_addr,
  output logic [DWL-1:0] rsp_data,
  output logic           rsp_last,
  output logic           rf_wen,
  output logic [AWL-1:0] rf_wa,
  output logic [DWL-1:0] rf_wd,
  output logic [AWL-1:0] rf_ra,
  input  logic [DWL-1:0] rf_rd,
  output logic           busy
);

  import rf_pkg::*;

  if (RF_LAT < 0 || RF_LAT > RF_LAT_MAX) begin : g_bad_rf_lat
    $error("rf_port_master: RF_LAT must be 0 or 1");
  end

  localparam logic [AWL-1:0] ADDR_ONE = AWL'(1);

  state_t         state_q;
  rf_op_t         op_q;
  rf_op_t         cmd_op_e;
  logic           rsp_valid_q;
  logic           rsp_last_q;
  logic [AWL-1:0] rsp_addr_q;
  logic [DWL-1:0] rsp_data_q;
  logic           rf_wen_q;
  logic [AWL-1:0] rf_wa_q;
  logic [DWL-1:0] rf_wd_q;
  logic [AWL-1:0] rf_ra_q;

  logic           seq_load;
  logic [AWL-1:0] seq_start;
  logic           seq_inc;
  logic [AWL-1:0] seq_addr;
  logic           seq_last;

  assign cmd_op_e  = rf_op_t'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  // Sequencer control mirrors the FSM: DUMP starts at 0, CLEAR at 1 (address 0
  // is never written); DUMP advances on each transferred beat, CLEAR every cycle.
  always_comb begin
    seq_load  = 1'b0;
    seq_start = '0;
    seq_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          seq_load  = (cmd_op_e == RF_DUMP) || (cmd_op_e == RF_CLEAR);
          seq_start = (cmd_op_e == RF_CLEAR) ? ADDR_ONE : '0;
        end
      end
      ST_RSP:  seq_inc = rsp_ready && (op_q == RF_DUMP) && !seq_last;
      ST_CLR:  seq_inc = !seq_last;
      default: ;
    endcase
  end

  rf_addr_seq #(.AWL(AWL)) u_addr_seq (
    .clk     (clk),
    .rst     (rst),
    .load_i  (seq_load),
    .start_i (seq_start),
    .inc_i   (seq_inc),
    .addr_o  (seq_addr),
    .last_o  (seq_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= RF_READ;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rf_wen_q    <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      rf_ra_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op_e;
            case (cmd_op_e)
              RF_READ: begin
                rf_ra_q <= cmd_addr;
                state_q <= ST_RD;
              end
              RF_WRITE: begin
                rf_wen_q <= (cmd_addr != '0);
                rf_wa_q  <= cmd_addr;
                rf_wd_q  <= cmd_data;
                state_q  <= ST_WR;
              end
              RF_DUMP: begin
                rf_ra_q <= '0;
                state_q <= ST_RD;
              end
              default: begin
                rf_wen_q <= 1'b1;
                rf_wa_q  <= ADDR_ONE;
                rf_wd_q  <= '0;
                state_q  <= ST_CLR;
              end
            endcase
          end
        end

        ST_WR: begin
          rf_wen_q <= 1'b0;
`ifdef RF_PORT_MASTER_WACK_EN
          rsp_valid_q <= 1'b1;
          rsp_addr_q  <= rf_wa_q;
          rsp_data_q  <= '0;
          rsp_last_q  <= 1'b1;
          state_q     <= ST_RSP;
`else
          state_q <= ST_IDLE;
`endif
        end

        // With an async-read RF the data is valid in RD; a registered RF needs
        // one more cycle (RD_WAIT) before the capture.
        ST_RD, ST_RD_WAIT: begin
          if (state_q == ST_RD_WAIT || RF_LAT == 0) begin
            rsp_valid_q <= 1'b1;
            rsp_addr_q  <= rf_ra_q;
            rsp_data_q  <= rf_rd;
            rsp_last_q  <= (op_q != RF_DUMP) || seq_last;
            state_q     <= ST_RSP;
          end else begin
            state_q <= ST_RD_WAIT;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (op_q == RF_DUMP && !seq_last) begin
              rf_ra_q <= seq_addr + ADDR_ONE;
              state_q <= ST_RD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_CLR: begin
          if (seq_last) begin
            rf_wen_q <= 1'b0;
`ifdef RF_PORT_MASTER_WACK_EN
            rsp_valid_q <= 1'b1;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b1;
            state_q     <= ST_RSP;
`else
            state_q <= ST_IDLE;
`endif
          end else begin
            rf_wa_q <= seq_addr + ADDR_ONE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rf_wen    = rf_wen_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;
  assign rf_ra     = rf_ra_q;

endmodule
